// File: rtl/freq_divider_multi.sv
// Multi-channel programmable square-wave / tick-strobe generator.
// Outputs are intended as clock enables for downstream logic.
module freq_divider_multi #(
    parameter int       NUM_CH       = 4,
    parameter int       CNT_W        = 25,
    parameter int       DEFAULT_HALF = 21000,
    parameter logic     OUT_INIT     = 1'b1,
    localparam int      CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              C_50Mhz,
    input  logic              reset,
    input  logic [NUM_CH-1:0] en,
    input  logic              sync_restart,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_half,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick
);

    logic [CNT_W-1:0]  half_q [NUM_CH];
    logic [CNT_W-1:0]  cnt_q  [NUM_CH];
    logic [CNT_W-1:0]  half_d [NUM_CH];
    logic [CNT_W-1:0]  cnt_d  [NUM_CH];
    logic [NUM_CH-1:0] out_d;
    logic [NUM_CH-1:0] tick_d;
    logic [NUM_CH-1:0] cfg_hit;

    // Decode the config write; an out-of-range index matches no channel.
    always_comb begin
        cfg_hit = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cfg_hit[i] = cfg_we && (int'(cfg_ch) == i);
        end
    end

    // Per-channel next state: restart/load first, then freeze, then count.
    always_comb begin
        out_d  = clk_out;
        tick_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            half_d[i] = half_q[i];
            cnt_d[i]  = cnt_q[i];
            if (cfg_hit[i]) begin
                half_d[i] = cfg_half;
            end
            if (sync_restart || cfg_hit[i]) begin
                cnt_d[i] = '0;
                out_d[i] = OUT_INIT;
            end else if (half_q[i] == '0) begin
                cnt_d[i] = '0;
            end else if (en[i]) begin
                if (cnt_q[i] == half_q[i] - CNT_W'(1)) begin
                    cnt_d[i]  = '0;
                    out_d[i]  = ~clk_out[i];
                    tick_d[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // State register with synchronous reset to the default ratio.
    always_ff @(posedge C_50Mhz) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                half_q[i] <= CNT_W'(DEFAULT_HALF);
                cnt_q[i]  <= '0;
            end
            clk_out <= {NUM_CH{OUT_INIT}};
            tick    <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                half_q[i] <= half_d[i];
                cnt_q[i]  <= cnt_d[i];
            end
            clk_out <= out_d;
            tick    <= tick_d;
        end
    end

endmodule

// File: tb/tb_freq_divider_multi.sv
// Directed bench for freq_divider_multi.
// Second small instance covers the out-of-range config write.
module tb_freq_divider_multi;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  en;
    logic        sync_restart;
    logic        cfg_we;
    logic [1:0]  cfg_ch;
    logic [24:0] cfg_half;
    logic [3:0]  clk_out;
    logic [3:0]  tick;

    logic        b_reset;
    logic [2:0]  b_en;
    logic        b_sync;
    logic        b_we;
    logic [1:0]  b_ch;
    logic [7:0]  b_half;
    logic [2:0]  b_clk_out;
    logic [2:0]  b_tick;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    freq_divider_multi dut (
        .C_50Mhz      (clk),
        .reset        (reset),
        .en           (en),
        .sync_restart (sync_restart),
        .cfg_we       (cfg_we),
        .cfg_ch       (cfg_ch),
        .cfg_half     (cfg_half),
        .clk_out      (clk_out),
        .tick         (tick)
    );

    freq_divider_multi #(
        .NUM_CH       (3),
        .CNT_W        (8),
        .DEFAULT_HALF (5),
        .OUT_INIT     (1'b1)
    ) dut_b (
        .C_50Mhz      (clk),
        .reset        (b_reset),
        .en           (b_en),
        .sync_restart (b_sync),
        .cfg_we       (b_we),
        .cfg_ch       (b_ch),
        .cfg_half     (b_half),
        .clk_out      (b_clk_out),
        .tick         (b_tick)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Level after k enabled cycles since restart/load with half-period h.
    function automatic logic m_out(input int k, input int h);
        if (h == 0) return 1'b1;
        return ((k / h) % 2 == 1) ? 1'b0 : 1'b1;
    endfunction

    function automatic logic m_tick(input int k, input int h);
        return (h != 0) && (k > 0) && (k % h == 0);
    endfunction

    task automatic check_all(input string tag, input int k,
                             input int h0, input int h1,
                             input int h2, input int h3);
        logic [3:0] eo;
        logic [3:0] et;
        int hv[4];
        hv[0] = h0; hv[1] = h1; hv[2] = h2; hv[3] = h3;
        for (int c = 0; c < 4; c++) begin
            eo[c] = m_out(k, hv[c]);
            et[c] = m_tick(k, hv[c]);
        end
        chk($sformatf("%s_out_k%0d", tag, k), 32'(clk_out), 32'(eo));
        chk($sformatf("%s_tick_k%0d", tag, k), 32'(tick), 32'(et));
    endtask

    initial begin
        logic [2:0] beo;
        logic [2:0] bet;
        reset = 1'b1; en = '0; sync_restart = 1'b0;
        cfg_we = 1'b0; cfg_ch = '0; cfg_half = '0;
        b_reset = 1'b1; b_en = '0; b_sync = 1'b0;
        b_we = 1'b0; b_ch = '0; b_half = '0;
        cyc(2);
        chk("rst_out", 32'(clk_out), 32'(4'hF));
        chk("rst_tick", 32'(tick), 32'(4'h0));
        chk("b_rst_out", 32'(b_clk_out), 32'(3'h7));
        chk("b_rst_tick", 32'(b_tick), 32'(3'h0));

        // Out-of-range write (cfg_ch=3, NUM_CH=3) must not disturb H=5.
        b_reset = 1'b0; b_en = 3'h7;
        for (int k = 1; k <= 12; k++) begin
            cyc(1);
            for (int c = 0; c < 3; c++) begin
                beo[c] = m_out(k, 5);
                bet[c] = m_tick(k, 5);
            end
            chk($sformatf("b_oor_out_k%0d", k), 32'(b_clk_out), 32'(beo));
            chk($sformatf("b_oor_tick_k%0d", k), 32'(b_tick), 32'(bet));
            b_we = (k == 2); b_ch = 2'd3; b_half = 8'd2;
        end
        b_we = 1'b0;

        // Default ratio: toggle at 21000 and 42000 cycles.
        reset = 1'b0; en = 4'hF;
        cyc(20999);
        chk("def_pre_out", 32'(clk_out), 32'(4'hF));
        chk("def_pre_tick", 32'(tick), 32'(4'h0));
        cyc(1);
        chk("def_t1_out", 32'(clk_out), 32'(4'h0));
        chk("def_t1_tick", 32'(tick), 32'(4'hF));
        cyc(1);
        chk("def_t1p_out", 32'(clk_out), 32'(4'h0));
        chk("def_t1p_tick", 32'(tick), 32'(4'h0));
        cyc(20998);
        chk("def_pre2_out", 32'(clk_out), 32'(4'h0));
        chk("def_pre2_tick", 32'(tick), 32'(4'h0));
        cyc(1);
        chk("def_t2_out", 32'(clk_out), 32'(4'hF));
        chk("def_t2_tick", 32'(tick), 32'(4'hF));
        cyc(1);
        chk("def_t2p_tick", 32'(tick), 32'(4'h0));

        // ch1 H=3; other channels stay high and quiet.
        cfg_we = 1'b1; cfg_ch = 2'd1; cfg_half = 25'd3;
        cyc(1);
        cfg_we = 1'b0;
        for (int k = 0; k <= 6; k++) begin
            if (k > 0) cyc(1);
            chk($sformatf("h3_out_k%0d", k), 32'(clk_out),
                32'({1'b1, 1'b1, m_out(k, 3), 1'b1}));
            chk($sformatf("h3_tick_k%0d", k), 32'(tick),
                32'({1'b0, 1'b0, m_tick(k, 3), 1'b0}));
        end

        // ch2 H=1 toggles every cycle, then H=0 freezes it.
        cfg_we = 1'b1; cfg_ch = 2'd2; cfg_half = 25'd1;
        cyc(1);
        cfg_we = 1'b0;
        for (int k = 0; k <= 3; k++) begin
            if (k > 0) cyc(1);
            chk($sformatf("h1_out_k%0d", k), 32'(clk_out[2]),
                32'(m_out(k, 1)));
            chk($sformatf("h1_tick_k%0d", k), 32'(tick[2]),
                32'(m_tick(k, 1)));
        end
        cfg_we = 1'b1; cfg_ch = 2'd2; cfg_half = 25'd0;
        cyc(1);
        cfg_we = 1'b0;
        for (int k = 0; k <= 4; k++) begin
            if (k > 0) cyc(1);
            chk($sformatf("h0_out_k%0d", k), 32'(clk_out[2]), 32'(1'b1));
            chk($sformatf("h0_tick_k%0d", k), 32'(tick[2]), 32'(1'b0));
            en[2] = (k % 2 == 0);
        end
        en = 4'hF;

        // ch1 H=5 with a 7-cycle enable gap at cnt=2.
        cfg_we = 1'b1; cfg_ch = 2'd1; cfg_half = 25'd5;
        cyc(1);
        cfg_we = 1'b0;
        cyc(2);
        chk("gap_pre_out", 32'(clk_out[1]), 32'(1'b1));
        en[1] = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            cyc(1);
            chk($sformatf("gap_out_k%0d", k), 32'(clk_out[1]), 32'(1'b1));
            chk($sformatf("gap_tick_k%0d", k), 32'(tick[1]), 32'(1'b0));
        end
        en[1] = 1'b1;
        cyc(2);
        chk("gap_re2_out", 32'(clk_out[1]), 32'(1'b1));
        chk("gap_re2_tick", 32'(tick[1]), 32'(1'b0));
        cyc(1);
        chk("gap_re3_out", 32'(clk_out[1]), 32'(1'b0));
        chk("gap_re3_tick", 32'(tick[1]), 32'(1'b1));

        // ch0 and ch3 H=4 loaded out of phase, then realigned.
        cfg_we = 1'b1; cfg_ch = 2'd0; cfg_half = 25'd4;
        cyc(1);
        cfg_we = 1'b0;
        cyc(1);
        cfg_we = 1'b1; cfg_ch = 2'd3; cfg_half = 25'd4;
        cyc(1);
        cfg_we = 1'b0;
        cyc(2);
        sync_restart = 1'b1;
        cyc(1);
        sync_restart = 1'b0;
        for (int k = 0; k <= 5; k++) begin
            if (k > 0) cyc(1);
            check_all("sync", k, 4, 5, 0, 4);
        end

        // Restart coincident with a write of H=6 to ch3.
        sync_restart = 1'b1;
        cfg_we = 1'b1; cfg_ch = 2'd3; cfg_half = 25'd6;
        cyc(1);
        sync_restart = 1'b0;
        cfg_we = 1'b0;
        for (int k = 0; k <= 12; k++) begin
            if (k > 0) cyc(1);
            check_all("syncwr", k, 4, 5, 0, 6);
        end

        // Reset mid-count restores the default ratio on ch1.
        cfg_we = 1'b1; cfg_ch = 2'd1; cfg_half = 25'd3;
        cyc(1);
        cfg_we = 1'b0;
        cyc(1);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        chk("mid_rst_out", 32'(clk_out), 32'(4'hF));
        chk("mid_rst_tick", 32'(tick), 32'(4'h0));
        cyc(3);
        chk("mid_rst3_out", 32'(clk_out), 32'(4'hF));
        chk("mid_rst3_tick", 32'(tick), 32'(4'h0));
        cyc(20996);
        chk("mid_pre_out", 32'(clk_out), 32'(4'hF));
        chk("mid_pre_tick", 32'(tick), 32'(4'h0));
        cyc(1);
        chk("mid_t1_out", 32'(clk_out), 32'(4'h0));
        chk("mid_t1_tick", 32'(tick), 32'(4'hF));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/freq_divider_multi.md
Name: freq_divider_multi

Overview:
Multi-channel programmable clock-enable/divider generator. It is the parametrised successor of the single fixed-ratio toggle divider. Each channel produces a square wave plus a one-cycle tick strobe from the system clock, with a runtime-loadable half-period, a per-channel enable and a global phase-aligned restart. It feeds peripheral timing (LED blink, UART/VGA strobes, slow FSM clocks) as clock enables, not as derived clocks.

Parameters:
- NUM_CH, 4, number of independent divider channels (1..16).
- CNT_W, 25, width of each channel's counter and half-period register.
- DEFAULT_HALF, 21000, half-period loaded into every channel at reset (cycles per output level).
- OUT_INIT, 1, reset/restart level of every clk_out bit.
- CH_W, max(1,$clog2(NUM_CH)), localparam; width of cfg_ch.

Ports:
- C_50Mhz  in  1  system clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- en  in  NUM_CH  per-channel count enable; level-sensitive.
- sync_restart  in  1  one-cycle pulse; re-phases all channels.
- cfg_we  in  1  write strobe for the half-period register.
- cfg_ch  in  CH_W  channel index written when cfg_we=1.
- cfg_half  in  CNT_W  new half-period H for channel cfg_ch.
- clk_out  out  NUM_CH  divided square wave per channel, registered.
- tick  out  NUM_CH  one-cycle strobe per channel, registered, coincident with each clk_out toggle.

Behaviour:
- Per-channel state: half[i] (CNT_W), cnt[i] (CNT_W), clk_out[i], tick[i]. All outputs are registered and there is no combinational path from inputs to outputs.
- Reset (C_50Mhz edge with reset=1): half[i]=DEFAULT_HALF, cnt[i]=0, clk_out[i]=OUT_INIT, tick[i]=0 for all i.
- Counting: when en[i]=1 and half[i]!=0:
  - if cnt[i]==half[i]-1: cnt[i]<=0, clk_out[i]<=~clk_out[i], tick[i]<=1.
  - else: cnt[i]<=cnt[i]+1, tick[i]<=0.
- Output period is 2*H cycles with 50% duty. H=1 toggles clk_out every cycle and holds tick high continuously while enabled.
- First toggle occurs H cycles after reset/restart/load. Concretely: tick is high in the cycle following the H-th enabled edge.
- en[i]=0: cnt[i] and clk_out[i] hold, tick[i]=0. Re-enabling resumes from the held count with no phase loss.
- half[i]==0: channel frozen. cnt[i]=0, clk_out[i] holds its current value, tick[i]=0, regardless of en.
- cfg_we=1 with cfg_ch<NUM_CH:
  - half[cfg_ch]<=cfg_half, cnt[cfg_ch]<=0, clk_out[cfg_ch]<=OUT_INIT, tick[cfg_ch]<=0 on that edge.
  - The new H governs counting from the next cycle.
  - Other channels are unaffected.
- cfg_we=1 with cfg_ch>=NUM_CH: ignored, no state change.
- sync_restart=1: for all channels, cnt<=0, clk_out<=OUT_INIT, tick<=0. half is unchanged. All channels with equal H stay phase-aligned afterwards.
- Priority on one edge: reset > sync_restart > cfg_we > counting.
  - If sync_restart and cfg_we coincide, the half write still lands; all channels, including the written one, restart.
- Reset asserted mid-count aborts immediately on that edge. There is no partial-period completion.
- Counter arithmetic is unsigned CNT_W bits. cnt never exceeds half-1 because every half change clears cnt, so no wrap occurs.

Test Plan:
- Reset, en=all 1, defaults -> each clk_out goes from 1 to 0 with tick=1 exactly 21000 cycles after reset release, then back to 1 at 42000; tick has exactly one cycle high per toggle.
- Write ch1 H=3, others default -> clk_out[1] period 6 cycles, tick[1] high every 3rd cycle; ch0/2/3 timing is unchanged.
- Write ch2 H=1 -> clk_out[2] toggles every cycle, tick[2] stays 1. Write ch2 H=0 -> clk_out[2] freezes at its current level and tick[2]=0.
- ch1 H=5; drop en[1] for 7 cycles at cnt=2 -> output and tick hold during the gap; the next toggle lands 3 enabled cycles after re-enable.
- ch0 H=4, ch3 H=4 started at different times; pulse sync_restart -> both go to OUT_INIT and toggle on the same cycle 4 cycles later. A simultaneous cfg_we to ch3 with H=6 makes ch3 restart with period 12.
- Assert reset mid-count with ch1 H=3 -> on that edge all outputs return to OUT_INIT, tick=0, and half[1] returns to 21000. A write with cfg_ch=NUM_CH (NUM_CH=4 -> cfg_ch=4 requires NUM_CH<2^CH_W; use NUM_CH=3) produces no change.
